// File: rtl/mem_bist.sv
// March BIST controller for a single-port memory: W0 up, (R0,W1) up, R1 down; reports pass, error count, first failing address.
// Latency: a full test occupies exactly 4*N cycles of busy after an accepted start; results are held in DONE.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored while busy.
module mem_bist #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] pattern,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_d,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_spo,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DONE} state_t;

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] pat;
   logic [DATA_W-1:0] exp_dat;
   logic              cmp_en;
   logic              mismatch;

   // Read compare: ascending pass expects P, descending pass expects ~P
   always_comb begin
      cmp_en   = (state == R0) || (state == R1);
      exp_dat  = (state == R1) ? ~pat : pat;
      mismatch = cmp_en && (mem_spo != exp_dat);
   end

   // Memory drive decoded only from registered state, address and pattern
   always_comb begin
      mem_a  = addr;
      mem_we = (state == W0) || (state == W1);
      mem_d  = '0;
      if (state == W0) mem_d = pat;
      else if (state == W1) mem_d = ~pat;
   end

   // March sequencer, error accounting and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         addr           <= '0;
         pat            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         // Only R0/R1 can mismatch, so this never collides with the clear on start
         if (mismatch) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (err_count == 16'd0) first_err_addr <= addr;
         end
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  pat            <= pattern;
                  addr           <= '0;
                  err_count      <= '0;
                  first_err_addr <= '0;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  busy           <= 1'b1;
                  state          <= W0;
               end
            end
            W0: begin
               if (addr == ADDR_MAX) begin
                  addr  <= '0;
                  state <= R0;
               end else begin
                  addr <= addr + 1'b1;
               end
            end
            R0: state <= W1;
            W1: begin
               // Last W1 hands over to R1 at the same (top) address
               if (addr == ADDR_MAX) begin
                  state <= R1;
               end else begin
                  addr  <= addr + 1'b1;
                  state <= R0;
               end
            end
            R1: begin
               if (addr == '0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  // Include a mismatch on this final compare edge
                  pass  <= (err_count == 16'd0) && !mismatch;
               end else begin
                  addr <= addr - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist with a 16x16 behavioural memory and stuck-at fault injection.
// Latency: each run expected to keep busy for 64 cycles and write 32 times.
// Backpressure: none; starts are issued only after the previous run completes, except the deliberate ignored start.
module tb_mem_bist;

   localparam int AW = 4;
   localparam int DW = 16;
   localparam int N  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] pattern = '0;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_d;
   logic          mem_we;
   logic [DW-1:0] mem_spo;
   logic          busy;
   logic          done;
   logic          pass;
   logic [15:0]   err_count;
   logic [AW-1:0] first_err_addr;

   mem_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
      .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_addr(first_err_addr)
   );

   always #5 clk = ~clk;

   // Behavioural memory: synchronous write, asynchronous read through stuck-at masks
   logic [DW-1:0] mem [N];
   logic [DW-1:0] sa0 [N];
   logic [DW-1:0] sa1 [N];

   always @(posedge clk) if (mem_we) mem[mem_a] <= mem_d;
   assign mem_spo = (mem[mem_a] & ~sa0[mem_a]) | sa1[mem_a];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   typedef struct packed {
      logic [15:0]           ec;
      logic [AW-1:0]         fa;
      logic                  ps;
      logic [N-1:0][DW-1:0]  fm;
   } exp_t;

   exp_t sb[$];

   function automatic logic [DW-1:0] faulty_read(input logic [DW-1:0] v, input int a);
      return (v & ~sa0[a]) | sa1[a];
   endfunction

   // Reference: the march algorithm run over a plain array with the current faults
   function automatic exp_t model(input logic [DW-1:0] p);
      exp_t          e;
      logic [DW-1:0] m [N];
      e = '0;
      for (int a = 0; a < N; a++) m[a] = p;
      for (int a = 0; a < N; a++) begin
         if (faulty_read(m[a], a) != p) begin
            if (e.ec == 0) e.fa = AW'(a);
            if (e.ec != 16'hFFFF) e.ec = e.ec + 1;
         end
         m[a] = ~p;
      end
      for (int a = N - 1; a >= 0; a--) begin
         if (faulty_read(m[a], a) != ~p) begin
            if (e.ec == 0) e.fa = AW'(a);
            if (e.ec != 16'hFFFF) e.ec = e.ec + 1;
         end
      end
      e.ps = (e.ec == 0);
      for (int a = 0; a < N; a++) e.fm[a] = m[a];
      return e;
   endfunction

   // Monitor: measures busy/write cycles and checks results when done rises
   int   busy_cnt = 0;
   int   we_cnt = 0;
   logic busy_q = 1'b0;
   logic done_q = 1'b0;
   exp_t got;

   always @(negedge clk) begin
      if (busy && !busy_q) begin
         busy_cnt = 0;
         we_cnt = 0;
      end
      if (busy) busy_cnt++;
      if (mem_we) we_cnt++;
      if (done && !done_q) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            got = sb.pop_front();
            check("err_count", 32'(err_count), 32'(got.ec));
            check("first_err_addr", 32'(first_err_addr), 32'(got.fa));
            check("pass", 32'(pass), 32'(got.ps));
            check("busy_cycles", 32'(busy_cnt), 32'(4 * N));
            check("we_cycles", 32'(we_cnt), 32'(2 * N));
            for (int a = 0; a < N; a++) check($sformatf("mem[%0d]", a), 32'(mem[a]), 32'(got.fm[a]));
         end
      end
      busy_q = busy;
      done_q = done;
   end

   task automatic run_start(input logic [DW-1:0] p, input bit expect_done);
      if (expect_done) sb.push_back(model(p));
      pattern = p;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done) break;
      end
      check("done_arrived", 32'(done), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_faults();
      for (int a = 0; a < N; a++) begin
         sa0[a] = '0;
         sa1[a] = '0;
      end
   endtask

   initial begin
      clear_faults();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_first_err", 32'(first_err_addr), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_a", 32'(mem_a), 32'd0);
      check("rst_mem_d", 32'(mem_d), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Clean run
      run_start(16'hA5A5, 1'b1);
      wait_done();

      // Bit 0 stuck-at-0 at address 5
      sa0[5] = 16'h0001;
      run_start(16'h0001, 1'b1);
      wait_done();
      clear_faults();

      // Bit 15 stuck-at-1 at addresses 3 and 9
      sa1[3] = 16'h8000;
      sa1[9] = 16'h8000;
      run_start(16'h0000, 1'b1);
      wait_done();
      clear_faults();

      // Start while busy is ignored; R1 catches bit 7 stuck-at-0 at 12
      sa0[12] = 16'h0080;
      run_start(16'h3C3C, 1'b1);
      repeat (9) @(posedge clk);
      #1 pattern = 16'hFFFF;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done();
      clear_faults();
      run_start(16'h3C3C, 1'b1);
      wait_done();

      // Reset in the middle of R0/W1 with an error already counted
      sa1[0] = 16'h0008;
      run_start(16'h0000, 1'b0);
      repeat (19) @(posedge clk);
      #1;
      check("pre_reset_err", 32'(err_count), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_mem_we", 32'(mem_we), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_err_count", 32'(err_count), 32'd0);
      clear_faults();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_start(16'hFFFF, 1'b1);
      wait_done();

      // Randomized patterns with a random single-bit stuck-at fault
      repeat (4) begin
         int       fa;
         int       fb;
         logic [DW-1:0] p;
         p  = DW'($urandom);
         fa = $urandom_range(0, N - 1);
         fb = $urandom_range(0, DW - 1);
         if ($urandom_range(0, 1) == 1) sa0[fa][fb] = 1'b1;
         else sa1[fa][fb] = 1'b1;
         run_start(p, 1'b1);
         wait_done();
         clear_faults();
      end

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
